// File: rtl/dso_pkg.sv
// Shared types and defaults for the DSO offset-correction path.
//   sat_code_t : rail flag attached to every corrected sample
//   DSO_DATA_W : default sample/offset width
//   DSO_NUM_CH : default channel count
package dso_pkg;

  localparam int DSO_DATA_W = 8;
  localparam int DSO_NUM_CH = 4;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_HI   = 2'b01,
    SAT_LO   = 2'b10
  } sat_code_t;

endpackage

// File: rtl/dso_offset_pipe_if.sv
// Sample-stream handshake bundle around dso_offset_pipe.
//   in_*  : tagged raw samples from the ADC capture front end
//   out_* : corrected samples toward the trigger/sample RAM writer
// master = the side that produces input samples and consumes outputs (front end / writer),
// slave  = the offset pipe itself.
interface dso_offset_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);

  logic              in_vld;
  logic              in_rdy;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_smpl;
  logic              out_vld;
  logic              out_rdy;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_smpl;
  logic [1:0]        out_sat;

  modport master (
    output in_vld, in_ch, in_smpl, out_rdy,
    input  in_rdy, out_vld, out_ch, out_smpl, out_sat
  );

  modport slave (
    input  in_vld, in_ch, in_smpl, out_rdy,
    output in_rdy, out_vld, out_ch, out_smpl, out_sat
  );

endinterface

// File: rtl/dso_sat_clamp.sv
// Combinational offset add and clamp to the unsigned sample range.
//   smpl_i : unsigned raw sample
//   off_i  : signed two's-complement offset
//   res_o  : clamped result
//   sat_o  : which rail was hit (SAT_NONE / SAT_HI / SAT_LO)
module dso_sat_clamp
  import dso_pkg::*;
#(
  parameter int DATA_W = DSO_DATA_W
) (
  input  logic [DATA_W-1:0] smpl_i,
  input  logic [DATA_W-1:0] off_i,
  output logic [DATA_W-1:0] res_o,
  output sat_code_t         sat_o
);

  // Two guard bits: top bit is the sign, next one flags overflow past all-ones.
  logic signed [DATA_W+1:0] sum;

  assign sum = $signed({2'b00, smpl_i}) + $signed({{2{off_i[DATA_W-1]}}, off_i});

  always_comb begin
    res_o = sum[DATA_W-1:0];
    sat_o = SAT_NONE;
    if (sum[DATA_W+1]) begin
      res_o = '0;
      sat_o = SAT_LO;
    end else if (sum[DATA_W]) begin
      res_o = '1;
      sat_o = SAT_HI;
    end
  end

endmodule

// File: rtl/dso_offset_pipe.sv
// Per-channel offset correction: two-stage pipeline adding a signed per-channel
// offset to each unsigned sample, clamping to range and flagging the rail hit.
//   clk, rst_n          : clock, async active-low reset
//   pipe_if (slave)     : in/out valid-ready sample streams
//   off_wr/addr/wdata   : offset table write port
//   cnt_addr/cnt_data   : saturation counter read (combinational)
//   cnt_clr             : synchronous clear of all counters
// Build option DSO_SATCNT_EN: when defined, per-channel saturation counters are
// built; otherwise cnt_data is tied to 0 and cnt_clr/cnt_addr are ignored.
module dso_offset_pipe
  import dso_pkg::*;
#(
  parameter int  DATA_W = DSO_DATA_W,
  parameter int  NUM_CH = DSO_NUM_CH,
  parameter int  CNT_W  = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  dso_offset_pipe_if.slave  pipe_if,
  input  logic              off_wr,
  input  logic [CH_W-1:0]   off_addr,
  input  logic [DATA_W-1:0] off_wdata,
  input  logic [CH_W-1:0]   cnt_addr,
  output logic [CNT_W-1:0]  cnt_data,
  input  logic              cnt_clr
);

  logic [DATA_W-1:0] off_q [NUM_CH];

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_smpl_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [DATA_W-1:0] s1_off_q;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_smpl_q;
  logic [CH_W-1:0]   out_ch_q;
  sat_code_t         out_sat_q;

  logic              in_rdy;
  logic              s1_load;
  logic              s2_load;
  logic [DATA_W-1:0] clamp_res;
  sat_code_t         clamp_sat;

  // out_rdy reaches in_rdy combinationally so a draining output frees S1 in the same cycle.
  assign in_rdy  = ~s1_vld_q | ~out_vld_q | pipe_if.out_rdy;
  assign s1_load = pipe_if.in_vld & in_rdy;
  assign s2_load = s1_vld_q & (~out_vld_q | pipe_if.out_rdy);

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (s1_load)      s1_vld_d = 1'b1;
    else if (s2_load) s1_vld_d = 1'b0;

    out_vld_d = out_vld_q;
    if (s2_load)              out_vld_d = 1'b1;
    else if (pipe_if.out_rdy) out_vld_d = 1'b0;
  end

  // Table read is from the registered copy, so a same-cycle write is not seen by the entering sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) off_q[i] <= '0;
    end else if (off_wr) begin
      off_q[off_addr] <= off_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_smpl_q <= '0;
      s1_ch_q   <= '0;
      s1_off_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_load) begin
        s1_smpl_q <= pipe_if.in_smpl;
        s1_ch_q   <= pipe_if.in_ch;
        s1_off_q  <= off_q[pipe_if.in_ch];
      end
    end
  end

  dso_sat_clamp #(.DATA_W(DATA_W)) u_clamp (
    .smpl_i (s1_smpl_q),
    .off_i  (s1_off_q),
    .res_o  (clamp_res),
    .sat_o  (clamp_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_smpl_q <= '0;
      out_ch_q   <= '0;
      out_sat_q  <= SAT_NONE;
    end else begin
      out_vld_q <= out_vld_d;
      if (s2_load) begin
        out_smpl_q <= clamp_res;
        out_ch_q   <= s1_ch_q;
        out_sat_q  <= clamp_sat;
      end
    end
  end

  assign pipe_if.in_rdy   = in_rdy;
  assign pipe_if.out_vld  = out_vld_q;
  assign pipe_if.out_smpl = out_smpl_q;
  assign pipe_if.out_ch   = out_ch_q;
  assign pipe_if.out_sat  = out_sat_q;

`ifdef DSO_SATCNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             sat_evt;

  assign sat_evt = out_vld_q & pipe_if.out_rdy & (out_sat_q != SAT_NONE);

  // Clear beats a same-cycle event; counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (sat_evt && (cnt_q[out_ch_q] != '1)) begin
      cnt_q[out_ch_q] <= cnt_q[out_ch_q] + CNT_W'(1);
    end
  end

  assign cnt_data = cnt_q[cnt_addr];
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, cnt_addr};
  assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_dso_offset_pipe.sv
// Directed testbench for dso_offset_pipe. Expected outputs are hand-computed and
// queued at acceptance; a negedge monitor compares every output handshake in order.
// Counter checks depend on DSO_SATCNT_EN (tied-to-zero check otherwise).
module tb_dso_offset_pipe;

  logic       clk;
  logic       rst_n;
  logic       off_wr;
  logic [1:0] off_addr;
  logic [7:0] off_wdata;
  logic [1:0] cnt_addr;
  logic [15:0] cnt_data;
  logic       cnt_clr;

  int n_chk = 0;
  int n_err = 0;
  int n_rx  = 0;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] smpl;
    logic [1:0] sat;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] stall_held;
  int         rx_base;

  dso_offset_pipe_if #(.DATA_W(8), .CH_W(2)) dif ();

  dso_offset_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe_if   (dif.slave),
    .off_wr    (off_wr),
    .off_addr  (off_addr),
    .off_wdata (off_wdata),
    .cnt_addr  (cnt_addr),
    .cnt_data  (cnt_data),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired n_chk=%0d n_err=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [7:0] s,
                      input logic [7:0] es, input logic [1:0] esat);
    int n = 0;
    dif.in_vld  = 1'b1;
    dif.in_ch   = ch;
    dif.in_smpl = s;
    @(negedge clk);
    while (!dif.in_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!dif.in_rdy) chk("accept_timeout", 32'(dif.in_rdy), 32'd1);
    else exp_q.push_back('{ch, es, esat});
    @(posedge clk);
    #1;
    dif.in_vld = 1'b0;
  endtask

  task automatic wr_off(input logic [1:0] a, input logic [7:0] d);
    off_wr    = 1'b1;
    off_addr  = a;
    off_wdata = d;
    @(posedge clk);
    #1;
    off_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (dif.out_vld && dif.out_rdy) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_smpl", 32'(dif.out_smpl), 32'(mon_e.smpl));
        chk("out_sat",  32'(dif.out_sat),  32'(mon_e.sat));
        chk("out_ch",   32'(dif.out_ch),   32'(mon_e.ch));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    dif.in_vld  = 1'b0;
    dif.in_ch   = 2'd0;
    dif.in_smpl = 8'h00;
    dif.out_rdy = 1'b1;
    off_wr      = 1'b0;
    off_addr    = 2'd0;
    off_wdata   = 8'h00;
    cnt_addr    = 2'd0;
    cnt_clr     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy",   32'(dif.in_rdy),   32'd1);
    chk("rst_out_vld",  32'(dif.out_vld),  32'd0);
    chk("rst_out_smpl", 32'(dif.out_smpl), 32'd0);
    chk("rst_out_ch",   32'(dif.out_ch),   32'd0);
    chk("rst_out_sat",  32'(dif.out_sat),  32'd0);
    chk("rst_cnt",      32'(cnt_data),     32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: sample presented after edge N, out_vld rises at edge N+2.
    wr_off(2'd0, 8'h10);
    dif.in_vld  = 1'b1;
    dif.in_ch   = 2'd0;
    dif.in_smpl = 8'h20;
    @(negedge clk);
    chk("lat_accept", 32'(dif.in_rdy), 32'd1);
    exp_q.push_back('{2'd0, 8'h30, 2'b00});
    @(posedge clk);
    #1;
    dif.in_vld = 1'b0;
    chk("lat_n1_vld", 32'(dif.out_vld), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n2_vld",  32'(dif.out_vld),  32'd1);
    chk("lat_n2_smpl", 32'(dif.out_smpl), 32'h30);
    wait_idle();

    // Clamp rails and exact edge values.
    wr_off(2'd1, 8'h10);
    send(2'd1, 8'hF8, 8'hFF, 2'b01);
    send(2'd1, 8'hEF, 8'hFF, 2'b00);
    wr_off(2'd2, 8'h80);
    send(2'd2, 8'h05, 8'h00, 2'b10);
    send(2'd2, 8'h80, 8'h00, 2'b00);
    send(2'd2, 8'hFF, 8'h7F, 2'b00);
    wait_idle();

    // 16 back-to-back samples with a 5-cycle output stall in the middle.
    rx_base = n_rx;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(2'(i % 2), 8'(i * 8), 8'(i * 8 + 16), 2'b00);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        dif.out_rdy = 1'b0;
        stall_held  = dif.out_smpl;
        chk("stall_vld", 32'(dif.out_vld), 32'd1);
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("stall_hold", 32'(dif.out_smpl), 32'(stall_held));
        end
        chk("stall_in_rdy", 32'(dif.in_rdy), 32'd0);
        dif.out_rdy = 1'b1;
      end
    join
    wait_idle();
    chk("stream_cnt", 32'(n_rx - rx_base), 32'd16);

    // Offset write coinciding with a ch3 accept: old offset used, new one next.
    off_wr    = 1'b1;
    off_addr  = 2'd3;
    off_wdata = 8'h20;
    send(2'd3, 8'h10, 8'h10, 2'b00);
    off_wr = 1'b0;
    send(2'd3, 8'h10, 8'h30, 2'b00);
    wait_idle();

`ifdef DSO_SATCNT_EN
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr  = 1'b0;
    cnt_addr = 2'd1;
    chk("cnt_clr0", 32'(cnt_data), 32'd0);
    for (int i = 0; i < 3; i++) send(2'd1, 8'hF8, 8'hFF, 2'b01);
    wait_idle();
    chk("cnt_three", 32'(cnt_data), 32'd3);
    cnt_addr = 2'd2;
    chk("cnt_ch2", 32'(cnt_data), 32'd0);
    for (int i = 0; i < 65538; i++) send(2'd1, 8'hF8, 8'hFF, 2'b01);
    wait_idle();
    cnt_addr = 2'd1;
    chk("cnt_stick", 32'(cnt_data), 32'hFFFF);
    send(2'd1, 8'hF8, 8'hFF, 2'b01);
    begin
      int n = 0;
      while (!dif.out_vld && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("cnt_evt_vld", 32'(dif.out_vld), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_evt", 32'(cnt_data), 32'd0);
    wait_idle();
`else
    cnt_clr  = 1'b0;
    cnt_addr = 2'd1;
    send(2'd1, 8'hF8, 8'hFF, 2'b01);
    wait_idle();
    chk("cnt_tied", 32'(cnt_data), 32'd0);
`endif

    // Fill both stages, then reset mid-stream.
    dif.out_rdy = 1'b0;
    send(2'd0, 8'h11, 8'h21, 2'b00);
    send(2'd0, 8'h22, 8'h32, 2'b00);
    chk("full_in_rdy",  32'(dif.in_rdy),  32'd0);
    chk("full_out_vld", 32'(dif.out_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 32'(dif.out_vld), 32'd0);
    chk("mid_rst_in_rdy",  32'(dif.in_rdy),  32'd1);
    dif.out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx_base = n_rx;
    send(2'd0, 8'h40, 8'h40, 2'b00);
    wait_idle();
    chk("post_rst_rx", 32'(n_rx - rx_base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
